// File: rtl/prog_loader.sv
// Program loader: parses a little-endian byte stream (count, words, checksum), broadcasts each
// word to the instruction stores, pads the tail with FILL_WORD and releases the CPU on success.
module prog_loader #(
    parameter int unsigned INSTR_WIDTH        = 16,
    parameter int unsigned ROM_REGISTER_COUNT = 2**10,
    parameter logic [INSTR_WIDTH-1:0] FILL_WORD = '0,
    localparam int unsigned ADDR_W = $clog2(ROM_REGISTER_COUNT)
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    output logic                   rx_ready,
    input  logic                   reload,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [INSTR_WIDTH-1:0] wr_data,
    output logic                   cpu_resetN,
    output logic                   load_done,
    output logic                   load_error
);

    localparam logic [16:0]     Depth17 = 17'(ROM_REGISTER_COUNT);
    localparam logic [ADDR_W:0] FillEnd = (ADDR_W + 1)'(ROM_REGISTER_COUNT);

    typedef enum logic [3:0] {
        StHdrLo, StHdrHi, StDataLo, StDataHi, StCsumLo, StCsumHi, StFill, StDone, StError
    } state_e;

    state_e                 state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [15:0]            idx_q, idx_d;
    logic [15:0]            sum_q, sum_d;
    logic [7:0]             lo_q, lo_d;
    logic [ADDR_W:0]        fill_q, fill_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
    logic [INSTR_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic                   xfer;
    logic [15:0]            rx_word;

    assign rx_ready = (state_q == StHdrLo)  || (state_q == StHdrHi)  ||
                      (state_q == StDataLo) || (state_q == StDataHi) ||
                      (state_q == StCsumLo) || (state_q == StCsumHi);
    assign xfer     = rx_valid && rx_ready;
    assign rx_word  = {rx_data, lo_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        lo_d      = lo_q;
        fill_d    = fill_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            StHdrLo: if (xfer) begin
                lo_d    = rx_data;
                state_d = StHdrHi;
            end
            StHdrHi: if (xfer) begin
                if (rx_word == 16'd0 || {1'b0, rx_word} > Depth17) begin
                    state_d = StError;
                end else begin
                    cnt_d   = rx_word;
                    idx_d   = 16'd0;
                    sum_d   = 16'd0;
                    state_d = StDataLo;
                end
            end
            StDataLo: if (xfer) begin
                lo_d    = rx_data;
                state_d = StDataHi;
            end
            StDataHi: if (xfer) begin
                wr_en_d   = 1'b1;
                wr_addr_d = idx_q[ADDR_W-1:0];
                wr_data_d = rx_word;
                sum_d     = sum_q + rx_word;
                idx_d     = idx_q + 16'd1;
                state_d   = (idx_q + 16'd1 == cnt_q) ? StCsumLo : StDataLo;
            end
            StCsumLo: if (xfer) begin
                lo_d    = rx_data;
                state_d = StCsumHi;
            end
            StCsumHi: if (xfer) begin
                if (rx_word != sum_q) begin
                    state_d = StError;
                end else if ({1'b0, cnt_q} == Depth17) begin
                    state_d = StDone;
                end else begin
                    // First pad write issues straight from the accept so padding starts next cycle.
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q[ADDR_W-1:0];
                    wr_data_d = FILL_WORD;
                    fill_d    = cnt_q[ADDR_W:0] + (ADDR_W + 1)'(1);
                    state_d   = StFill;
                end
            end
            StFill: begin
                if (fill_q == FillEnd) begin
                    state_d = StDone;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = fill_q[ADDR_W-1:0];
                    wr_data_d = FILL_WORD;
                    fill_d    = fill_q + (ADDR_W + 1)'(1);
                end
            end
            StDone, StError: if (reload) state_d = StHdrLo;
            default: state_d = StHdrLo;
        endcase
        // Status flags follow the next state so they change on the same edge as the state.
        done_d  = (state_d == StDone);
        error_d = (state_d == StError);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= StHdrLo;
            cnt_q     <= '0;
            idx_q     <= '0;
            sum_q     <= '0;
            lo_q      <= '0;
            fill_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            lo_q      <= lo_d;
            fill_q    <= fill_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign load_done  = done_q;
    assign cpu_resetN = done_q;
    assign load_error = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader with an 8-word store: scoreboarded writes, a header vector table and
// hand-written sequences for fill timing, checksum wrap, reload and mid-load reset.
module tb_prog_loader;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready;
    logic       reload = 1'b0;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [15:0] wr_data;
    logic       cpu_resetN;
    logic       load_done;
    logic       load_error;

    prog_loader #(
        .INSTR_WIDTH       (16),
        .ROM_REGISTER_COUNT(8),
        .FILL_WORD         (16'h0000)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .reload    (reload),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_resetN(cpu_resetN),
        .load_done (load_done),
        .load_error(load_error)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic       exp_err;
    } hdr_vec_t;

    wr_t      exp_q[$];
    wr_t      got;
    int       errors = 0;
    int       checks = 0;
    int       cyc = 0;
    int       wr_count = 0;
    int       wr_cyc[8];
    logic [7:0] s1[10];
    hdr_vec_t hv[5];

    always @(posedge Clk) cyc <= cyc + 1;

    // Scoreboard: every observed write must match the oldest expected one.
    always @(negedge Clk) begin
        if (wr_en === 1'b1) begin
            wr_count++;
            wr_cyc[wr_addr] = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write",
                         wr_addr, wr_data);
            end else begin
                got = exp_q.pop_front();
                if (wr_addr !== got.addr || wr_data !== got.data) begin
                    errors++;
                    $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                             wr_addr, wr_data, got.addr, got.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_wr(input int a, input logic [15:0] d);
        wr_t e;
        e.addr = a[2:0];
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge right after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        n = 0;
        if (gap) repeat ($urandom_range(0, 3)) @(negedge Clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (rx_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got rx_ready=%b, required 1", rx_ready);
        end
        @(negedge Clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        Reset    = 1'b1;
        rx_valid = 1'b0;
        reload   = 1'b0;
        repeat (2) @(negedge Clk);
        Reset    = 1'b0;
        wr_count = 0;
        exp_q.delete();
    endtask

    task automatic run_s1(input bit gap);
        int csum_cyc;
        int done_cyc;
        int n;
        bit fill_ok;
        push_wr(0, 16'h1234);
        push_wr(1, 16'hABCD);
        push_wr(2, 16'h0001);
        for (int a = 3; a < 8; a++) push_wr(a, 16'h0000);
        for (int i = 0; i < 10; i++) send_byte(s1[i], gap);
        csum_cyc = cyc;
        n = 0;
        while (load_done !== 1'b1 && n < 40) begin
            @(negedge Clk);
            n++;
        end
        done_cyc = cyc;
        check("s1_done", load_done, 1);
        check("s1_cpu_resetN", cpu_resetN, 1);
        check("s1_error", load_error, 0);
        check("s1_ready", rx_ready, 0);
        check("s1_first_fill_cycle", wr_cyc[3], csum_cyc);
        fill_ok = 1'b1;
        for (int a = 3; a < 7; a++) if (wr_cyc[a+1] != wr_cyc[a] + 1) fill_ok = 1'b0;
        check("s1_fill_consecutive", fill_ok, 1);
        check("s1_done_cycle", done_cyc, wr_cyc[7] + 1);
        repeat (3) @(negedge Clk);
        check("s1_wr_count", wr_count, 8);
        check("s1_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1);
    end

    initial begin
        s1 = '{8'h03, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h00, 8'h02, 8'hBE};
        hv[0] = '{lo: 8'h00, hi: 8'h00, exp_err: 1'b1};
        hv[1] = '{lo: 8'h09, hi: 8'h00, exp_err: 1'b1};
        hv[2] = '{lo: 8'h08, hi: 8'h00, exp_err: 1'b0};
        hv[3] = '{lo: 8'h01, hi: 8'h00, exp_err: 1'b0};
        hv[4] = '{lo: 8'h00, hi: 8'h01, exp_err: 1'b1};

        // Reset values
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        check("rst_ready", rx_ready, 1);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_cpu_resetN", cpu_resetN, 0);
        check("rst_done", load_done, 0);
        check("rst_error", load_error, 0);

        // Good load with padding
        run_s1(1'b0);

        // Bad checksum
        do_reset();
        push_wr(0, 16'h1234);
        push_wr(1, 16'hABCD);
        push_wr(2, 16'h0001);
        for (int i = 0; i < 8; i++) send_byte(s1[i], 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'hBE, 1'b0);
        check("bad_error", load_error, 1);
        check("bad_cpu_resetN", cpu_resetN, 0);
        check("bad_ready", rx_ready, 0);
        check("bad_done", load_done, 0);
        repeat (4) @(negedge Clk);
        check("bad_wr_count", wr_count, 3);
        check("bad_queue_empty", exp_q.size(), 0);
        reload = 1'b1;
        @(negedge Clk);
        reload = 1'b0;
        check("err_reload_error", load_error, 0);
        check("err_reload_ready", rx_ready, 1);

        // Header vector table
        for (int v = 0; v < 5; v++) begin
            do_reset();
            send_byte(hv[v].lo, 1'b0);
            send_byte(hv[v].hi, 1'b0);
            check("hdr_error", load_error, hv[v].exp_err);
            check("hdr_ready", rx_ready, !hv[v].exp_err);
            check("hdr_cpu_resetN", cpu_resetN, 0);
            repeat (2) @(negedge Clk);
            check("hdr_wr_count", wr_count, 0);
        end

        // Full depth, checksum wraps; a stray reload mid-load must be ignored
        do_reset();
        for (int a = 0; a < 8; a++) push_wr(a, 16'hFFFF);
        send_byte(8'h08, 1'b0);
        send_byte(8'h00, 1'b0);
        reload = 1'b1;
        @(negedge Clk);
        reload = 1'b0;
        for (int i = 0; i < 16; i++) send_byte(8'hFF, 1'b0);
        send_byte(8'hF8, 1'b0);
        send_byte(8'hFF, 1'b0);
        check("full_done", load_done, 1);
        check("full_cpu_resetN", cpu_resetN, 1);
        repeat (3) @(negedge Clk);
        check("full_wr_count", wr_count, 8);
        check("full_queue_empty", exp_q.size(), 0);

        // Random valid gaps, then reload from DONE
        do_reset();
        run_s1(1'b1);
        reload = 1'b1;
        @(negedge Clk);
        reload = 1'b0;
        check("reload_done", load_done, 0);
        check("reload_cpu_resetN", cpu_resetN, 0);
        check("reload_ready", rx_ready, 1);

        // Reset coinciding with a DATA_HI accept must suppress that write
        do_reset();
        push_wr(0, 16'h1234);
        for (int i = 0; i < 5; i++) send_byte(s1[i], 1'b0);
        rx_valid = 1'b1;
        rx_data  = 8'hAB;
        Reset    = 1'b1;
        @(negedge Clk);
        Reset    = 1'b0;
        rx_valid = 1'b0;
        check("mid_rst_wr_en", wr_en, 0);
        check("mid_rst_wr_addr", wr_addr, 0);
        check("mid_rst_wr_data", wr_data, 0);
        check("mid_rst_ready", rx_ready, 1);
        check("mid_rst_error", load_error, 0);
        repeat (3) @(negedge Clk);
        check("mid_rst_wr_count", wr_count, 1);
        check("mid_rst_queue_empty", exp_q.size(), 0);
        wr_count = 0;
        run_s1(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
